instruction_refill_engine: RTL and testbench

Services instruction-cache line refills on the L2 side of the L1 instruction cache's replacement controller. Accepts one block-aligned word address per miss over a valid/ready handshake, fetches the line from the next memory level one word at a time with requests pipelined, and assembles the words into a full block. Returns the block to the L1 over a second valid/ready handshake. Exactly one refill is in flight at a time.

---
 rtl/instruction_refill_engine_pkg.sv | 28 ++
 rtl/instruction_refill_engine_refill_block_buffer.sv | 36 +++
 rtl/instruction_refill_engine.sv | 122 ++++++++++++
 tb/tb_instruction_refill_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_refill_engine_pkg.sv
// instruction_refill_engine_pkg: shared types, derived widths and helpers for the refill engine
//
// Contents:
//   clog2           ceiling log2, used to size word indices and counters
//   refill_state_t  FSM encoding (IDLE=0, ISSUE=1, DRAIN=2, RESPOND=3)
//   WORD_SELECT, W  derived word-index width and word width for the default geometry
package instruction_refill_engine_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        RESPOND = 2'd3
    } refill_state_t;

    localparam int WORD_SIZE_DEF      = 4;
    localparam int WORD_PER_BLOCK_DEF = 16;
    localparam int W                  = 8 * WORD_SIZE_DEF;
    localparam int WORD_SELECT        = clog2(WORD_PER_BLOCK_DEF - 1);

endpackage

// File: rtl/instruction_refill_engine_refill_block_buffer.sv
// refill_block_buffer: word-addressable line buffer that assembles one cache block
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears every word)
//   clr         synchronous clear of the whole block (wins over we)
//   we, idx     write din into word slot idx
//   din         one memory word
//   block       flat view of all words, word 0 in the least-significant bits
module refill_block_buffer #(
    parameter int WORDS = 16,
    parameter int WIDTH = 32,
    parameter int IDX   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    input  logic [IDX-1:0]         idx,
    input  logic [WIDTH-1:0]       din,
    output logic [WORDS*WIDTH-1:0] block
);

    logic [WORDS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (clr)
            mem <= '0;
        else if (we)
            mem[idx] <= din;
    end

    assign block = mem;

endmodule

// File: rtl/instruction_refill_engine.sv
// instruction_refill_engine: refills one L1 instruction-cache line from the next memory level
//
// Ports:
//   CLK, RST_N                    clock, asynchronous active-low reset
//   ADDRESS_TO_L2_VALID_INS/READY L1 miss-address handshake
//   ADDRESS_TO_L2_INS             word address of the missing line (low bits ignored)
//   DATA_FROM_L2_VALID_INS/READY  assembled-block handshake back to the L1
//   DATA_FROM_L2_INS              assembled block, word 0 in the low bits
//   MEM_ADDR_VALID/READY          pipelined word-read request handshake
//   MEM_ADDR                      word address requested
//   MEM_DATA_VALID, MEM_DATA      in-order read responses, no backpressure
module instruction_refill_engine
    import instruction_refill_engine_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BLOCK_WIDTH    = 512,
    parameter int WORD_SIZE      = 4,
    parameter int WORD_PER_BLOCK = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ADDRESS_TO_L2_VALID_INS,
    output logic                     ADDRESS_TO_L2_READY_INS,
    input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
    output logic                     DATA_FROM_L2_VALID_INS,
    input  logic                     DATA_FROM_L2_READY_INS,
    output logic [BLOCK_WIDTH-1:0]   DATA_FROM_L2_INS,
    output logic                     MEM_ADDR_VALID,
    input  logic                     MEM_ADDR_READY,
    output logic [ADDRESS_WIDTH-3:0] MEM_ADDR,
    input  logic                     MEM_DATA_VALID,
    input  logic [8*WORD_SIZE-1:0]   MEM_DATA
);

    localparam int SEL    = clog2(WORD_PER_BLOCK - 1);
    localparam int WD     = 8 * WORD_SIZE;
    localparam int AW     = ADDRESS_WIDTH - 2;
    localparam int LAST_I = WORD_PER_BLOCK - 1;
    localparam logic [SEL:0]  LAST      = LAST_I[SEL:0];
    localparam logic [AW-1:0] LINE_MASK = ~((AW'(1) << SEL) - AW'(1));

    refill_state_t state;
    logic [SEL:0]  issue_cnt;
    logic [SEL:0]  rx_cnt;
    logic          accept;
    logic          capture;

    assign accept  = state == IDLE && ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS;
    // Responses are only meaningful while a refill is collecting words.
    assign capture = (state == ISSUE || state == DRAIN) && MEM_DATA_VALID;

    refill_block_buffer #(
        .WORDS (WORD_PER_BLOCK),
        .WIDTH (WD),
        .IDX   (SEL)
    ) u_buffer (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (accept),
        .we    (capture),
        .idx   (rx_cnt[SEL-1:0]),
        .din   (MEM_DATA),
        .block (DATA_FROM_L2_INS)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state                   <= IDLE;
            issue_cnt               <= '0;
            rx_cnt                  <= '0;
            ADDRESS_TO_L2_READY_INS <= 1'b0;
            MEM_ADDR_VALID          <= 1'b0;
            MEM_ADDR                <= '0;
            DATA_FROM_L2_VALID_INS  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Raised in the first cycle out of reset, then held until an address is taken.
                    ADDRESS_TO_L2_READY_INS <= 1'b1;
                    if (accept) begin
                        ADDRESS_TO_L2_READY_INS <= 1'b0;
                        MEM_ADDR_VALID          <= 1'b1;
                        MEM_ADDR                <= ADDRESS_TO_L2_INS & LINE_MASK;
                        issue_cnt               <= '0;
                        rx_cnt                  <= '0;
                        state                   <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    // MEM_ADDR tracks base + issue_cnt; the last request leaves it in place.
                    if (state == ISSUE && MEM_ADDR_READY) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST) begin
                            MEM_ADDR_VALID <= 1'b0;
                            state          <= DRAIN;
                        end else begin
                            MEM_ADDR <= MEM_ADDR + AW'(1);
                        end
                    end
                    // The final capture wins even if issuing has not formally finished.
                    if (capture) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == LAST) begin
                            MEM_ADDR_VALID         <= 1'b0;
                            DATA_FROM_L2_VALID_INS <= 1'b1;
                            state                  <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    if (DATA_FROM_L2_READY_INS) begin
                        DATA_FROM_L2_VALID_INS  <= 1'b0;
                        ADDRESS_TO_L2_READY_INS <= 1'b1;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_refill_engine.sv
// tb_instruction_refill_engine: table-driven refill scenarios with a block scoreboard and a memory model
module tb_instruction_refill_engine;

    logic         CLK;
    logic         RST_N;
    logic         ADDRESS_TO_L2_VALID_INS;
    logic         ADDRESS_TO_L2_READY_INS;
    logic [29:0]  ADDRESS_TO_L2_INS;
    logic         DATA_FROM_L2_VALID_INS;
    logic         DATA_FROM_L2_READY_INS;
    logic [511:0] DATA_FROM_L2_INS;
    logic         MEM_ADDR_VALID;
    logic         MEM_ADDR_READY;
    logic [29:0]  MEM_ADDR;
    logic         MEM_DATA_VALID;
    logic [31:0]  MEM_DATA;

    instruction_refill_engine dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
        .MEM_ADDR_VALID          (MEM_ADDR_VALID),
        .MEM_ADDR_READY          (MEM_ADDR_READY),
        .MEM_ADDR                (MEM_ADDR),
        .MEM_DATA_VALID          (MEM_DATA_VALID),
        .MEM_DATA                (MEM_DATA)
    );

    typedef struct {
        logic [29:0] addr;
        logic [31:0] dbase;
        int          stall_word;
        int          stall_len;
        bit          burst;
        int          rdy_delay;
        bit          spur;
        int          exp_lat;
    } vec_t;

    int           cmp_cnt = 0;
    int           err_cnt = 0;
    logic [511:0] exp_q[$];
    logic [29:0]  pend[$];
    logic [29:0]  issued[$];
    logic [31:0]  data_base = 32'h0;
    int           stall_word = -1;
    int           stall_len = 0;
    int           stall_done = 0;
    bit           burst = 0;
    bit           spur = 0;
    vec_t         vecs[5];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_block(input logic [31:0] db);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = db + 32'(i);
        return b;
    endfunction

    // Memory model: records accepted requests just before the accepting edge, answers one
    // cycle later in order; optional stalls, burst gaps and spurious responses.
    initial begin
        logic        chk_hold;
        logic [29:0] hold_addr;
        logic [29:0] a;
        int          rcyc;
        chk_hold       = 1'b0;
        hold_addr      = '0;
        rcyc           = 0;
        MEM_ADDR_READY = 1'b1;
        MEM_DATA_VALID = 1'b0;
        MEM_DATA       = '0;
        forever begin
            @(negedge CLK);
            if (chk_hold) begin
                chk("mem_hold_valid", MEM_ADDR_VALID, 1'b1);
                chk("mem_hold_addr", MEM_ADDR, hold_addr);
            end
            chk_hold  = MEM_ADDR_VALID && !MEM_ADDR_READY;
            hold_addr = MEM_ADDR;
            if (MEM_ADDR_VALID && MEM_ADDR_READY) begin
                pend.push_back(MEM_ADDR);
                issued.push_back(MEM_ADDR);
            end
            @(posedge CLK);
            #1;
            rcyc++;
            if (MEM_ADDR_VALID && issued.size() == stall_word && stall_done < stall_len) begin
                MEM_ADDR_READY = 1'b0;
                stall_done++;
            end else begin
                MEM_ADDR_READY = 1'b1;
            end
            if (pend.size() > 0 && (!burst || (rcyc % 8) < 4)) begin
                a              = pend.pop_front();
                MEM_DATA_VALID = 1'b1;
                MEM_DATA       = data_base + 32'(a[3:0]);
            end else if (pend.size() == 0 && spur) begin
                MEM_DATA_VALID = 1'b1;
                MEM_DATA       = 32'hDEAD_BEEF;
            end else begin
                MEM_DATA_VALID = 1'b0;
                MEM_DATA       = '0;
            end
        end
    end

    // Scoreboard: a block handshake completes at the edge following this sample.
    always @(negedge CLK) begin
        if (DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 1'b1, 1'b0);
            end else begin
                chk("block", DATA_FROM_L2_INS, exp_q.pop_front());
            end
        end
    end

    task automatic run_refill(input vec_t v, input string tag);
        logic [29:0]  base;
        logic [511:0] held;
        int           n;
        base       = v.addr & ~30'hF;
        issued.delete();
        data_base  = v.dbase;
        stall_word = v.stall_word;
        stall_len  = v.stall_len;
        stall_done = 0;
        burst      = v.burst;
        ADDRESS_TO_L2_INS       = v.addr;
        ADDRESS_TO_L2_VALID_INS = 1'b1;
        n = 0;
        while (!ADDRESS_TO_L2_READY_INS && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, "/addr_ready"}, ADDRESS_TO_L2_READY_INS, 1'b1);
        exp_q.push_back(mk_block(v.dbase));
        @(posedge CLK);
        #1;
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        chk({tag, "/ready_drop"}, ADDRESS_TO_L2_READY_INS, 1'b0);
        chk({tag, "/mem_valid_rise"}, MEM_ADDR_VALID, 1'b1);
        chk({tag, "/first_addr"}, MEM_ADDR, base);
        n = 1;
        while (!DATA_FROM_L2_VALID_INS && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, "/data_valid"}, DATA_FROM_L2_VALID_INS, 1'b1);
        if (v.exp_lat != 0) chk({tag, "/latency"}, n, v.exp_lat);
        held = DATA_FROM_L2_INS;
        spur = v.spur;
        for (int i = 0; i < v.rdy_delay; i++) begin
            @(posedge CLK);
            #1;
            chk({tag, "/hold_valid"}, DATA_FROM_L2_VALID_INS, 1'b1);
            chk({tag, "/hold_data"}, DATA_FROM_L2_INS, held);
            chk({tag, "/hold_ready_low"}, ADDRESS_TO_L2_READY_INS, 1'b0);
        end
        spur = 1'b0;
        DATA_FROM_L2_READY_INS = 1'b1;
        @(posedge CLK);
        #1;
        DATA_FROM_L2_READY_INS = 1'b0;
        chk({tag, "/valid_drop"}, DATA_FROM_L2_VALID_INS, 1'b0);
        chk({tag, "/ready_back"}, ADDRESS_TO_L2_READY_INS, 1'b1);
        chk({tag, "/issue_count"}, issued.size(), 16);
        for (int i = 0; i < issued.size() && i < 16; i++)
            chk($sformatf("%s/issue_addr%0d", tag, i), issued[i], base + 30'(i));
    endtask

    initial begin
        int   n;
        vec_t post;
        vecs[0] = '{30'h0000_1234, 32'hA000_0000, -1, 0, 1'b0, 0,  1'b0, 18};
        vecs[1] = '{30'h0000_1234, 32'hA000_0000, 5,  3, 1'b0, 0,  1'b0, 21};
        vecs[2] = '{30'h0000_1234, 32'hA000_0000, -1, 0, 1'b1, 10, 1'b1, 0};
        vecs[3] = '{30'h3FFF_FFFF, 32'h5A5A_0000, 0,  2, 1'b0, 2,  1'b0, 20};
        vecs[4] = '{30'h0000_0000, 32'h0123_4567, 15, 1, 1'b0, 1,  1'b0, 19};
        post    = '{30'h0000_0040, 32'hD000_0000, -1, 0, 1'b0, 0,  1'b0, 18};

        RST_N                   = 1'b0;
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        ADDRESS_TO_L2_INS       = '0;
        DATA_FROM_L2_READY_INS  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst/ready", ADDRESS_TO_L2_READY_INS, 1'b0);
        chk("rst/mem_valid", MEM_ADDR_VALID, 1'b0);
        chk("rst/mem_addr", MEM_ADDR, 30'h0);
        chk("rst/data_valid", DATA_FROM_L2_VALID_INS, 1'b0);
        chk("rst/data", DATA_FROM_L2_INS, 512'h0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rel/ready", ADDRESS_TO_L2_READY_INS, 1'b1);
        chk("rel/mem_valid", MEM_ADDR_VALID, 1'b0);
        chk("rel/data_valid", DATA_FROM_L2_VALID_INS, 1'b0);

        for (int k = 0; k < 5; k++) begin
            run_refill(vecs[k], $sformatf("vec%0d", k));
            if (k == 0) begin
                spur = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                spur = 1'b0;
                @(posedge CLK);
                #1;
                chk("idle_spur/data", DATA_FROM_L2_INS, mk_block(32'hA000_0000));
                chk("idle_spur/ready", ADDRESS_TO_L2_READY_INS, 1'b1);
                chk("idle_spur/mem_valid", MEM_ADDR_VALID, 1'b0);
                chk("idle_spur/data_valid", DATA_FROM_L2_VALID_INS, 1'b0);
            end
        end

        issued.delete();
        data_base  = 32'hC000_0000;
        stall_word = -1;
        stall_len  = 0;
        burst      = 1'b0;
        ADDRESS_TO_L2_INS       = 30'h0000_1234;
        ADDRESS_TO_L2_VALID_INS = 1'b1;
        n = 0;
        while (!ADDRESS_TO_L2_READY_INS && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        @(posedge CLK);
        #1;
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        n = 0;
        while (issued.size() < 8 && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("abort/reached_word8", issued.size() >= 8, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("abort/ready", ADDRESS_TO_L2_READY_INS, 1'b0);
        chk("abort/mem_valid", MEM_ADDR_VALID, 1'b0);
        chk("abort/mem_addr", MEM_ADDR, 30'h0);
        chk("abort/data_valid", DATA_FROM_L2_VALID_INS, 1'b0);
        chk("abort/data", DATA_FROM_L2_INS, 512'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("abort_rel/data", DATA_FROM_L2_INS, 512'h0);
        chk("abort_rel/ready", ADDRESS_TO_L2_READY_INS, 1'b1);
        chk("abort_rel/mem_valid", MEM_ADDR_VALID, 1'b0);
        run_refill(post, "post_reset");

        repeat (2) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
